div_share_arbiter: RTL
======================

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_REQ, 4, number of requesters (2..8).
- NUMER_DW, 16, numerator and quotient width.
- DENOM_DW, 16, denominator width.
- TIMEOUT_CYC, 64, maximum cycles to wait for a quotient.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req  in  NUM_REQ  per-requester divide request, level.
- i_numer_bus  in  NUM_REQ*NUMER_DW  packed numerators, requester k at bits [k*NUMER_DW +: NUMER_DW].
- i_denom_bus  in  NUM_REQ*DENOM_DW  packed denominators, same packing.
- o_grant  out  NUM_REQ  one-hot accept pulse.
- o_div_en  out  1  start pulse to the shared divider.
- o_div_numer  out  NUMER_DW  divider numerator.
- o_div_denom  out  DENOM_DW  divider denominator.
- i_div_quotient  in  NUMER_DW  divider quotient.
- i_div_quotient_vld  in  1  divider quotient valid pulse.
- o_result  out  NUMER_DW  quotient returned to the winner.
- o_result_id  out  clog2(NUM_REQ)  index of the requester that owns o_result.
- o_result_vld  out  1  result valid pulse.
- o_dbz  out  1  divide-by-zero flag, qualified by o_result_vld.
- o_timeout  out  1  sticky timeout error.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT and DONE; exactly one divide SHALL be in flight at a time.
REQ-004 In IDLE with i_req nonzero, the block SHALL select the first asserted requester at or after rr_ptr (mod NUM_REQ), latch its operands and index, and go to ISSUE.
REQ-005 In IDLE with i_req zero, the FSM SHALL remain in IDLE.
REQ-006 In ISSUE, o_grant[winner] SHALL pulse for exactly one cycle and rr_ptr SHALL become winner+1 (mod NUM_REQ).
REQ-007 Requesters SHALL hold i_req and operands until their grant; o_grant SHALL be the only acceptance indication.
REQ-008 In ISSUE with a nonzero latched denominator, o_div_en SHALL pulse for one cycle, o_div_numer and o_div_denom SHALL carry the latched operands, and the FSM SHALL go to WAIT.
REQ-009 In ISSUE with a zero latched denominator, o_div_en SHALL stay 0, the result SHALL be set to all-ones with o_dbz=1, and the FSM SHALL go to DONE.
REQ-010 In WAIT, i_div_quotient SHALL be captured when i_div_quotient_vld=1, and the FSM SHALL go to DONE.
REQ-011 In WAIT, a counter SHALL increment each cycle; if it reaches TIMEOUT_CYC before the quotient is valid, the block SHALL set o_timeout=1, produce result 0 with o_dbz=0, and go to DONE.
REQ-012 i_div_quotient_vld SHALL be ignored outside WAIT.
REQ-013 In DONE, o_result_vld SHALL pulse for one cycle with o_result and o_result_id stable, then the FSM SHALL return to IDLE.
REQ-014 Latency from the IDLE cycle with a request to o_result_vld SHALL be 3 cycles for divide-by-zero, and 3 plus the divider latency for a normal divide.
REQ-015 o_div_numer and o_div_denom SHALL hold their values from ISSUE until the next ISSUE.
REQ-016 A requester that deasserts i_req while still ungranted SHALL NOT be granted.
REQ-017 A request that arrives mid-operation SHALL wait; requesters that remain asserted SHALL each be served within NUM_REQ grants.

Reset
REQ-018 While i_rst_n=0 at a clock edge, the block SHALL set FSM=IDLE, rr_ptr=0, timeout counter=0, and all outputs to 0, including sticky o_timeout.
REQ-019 A reset mid-operation SHALL discard the in-flight divide; a late i_div_quotient_vld after reset SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single divide: req0 with 1000/7 -> one o_grant[0] and one o_div_en pulse, then o_result=142, o_result_id=0, o_dbz=0.
- Divide by zero: req2 with 55/0 -> no o_div_en, o_result=0xFFFF, o_dbz=1 three cycles after the request.
- Round robin: i_req=4'b1111 held with rr_ptr=0 -> grant order 0,1,2,3,0; each result_id matches the grant.
- Contention while busy: req1 asserted during WAIT of req3 -> grant1 issued only after req3's o_result_vld, with the correct quotient for each.
- Timeout: stub divider never asserts valid -> o_result_vld after TIMEOUT_CYC WAIT cycles, o_result=0, o_timeout stays 1 until reset.
- Reset in WAIT: i_rst_n low for one cycle, then a stale i_div_quotient_vld -> no o_result_vld and rr_ptr=0.

Source files
------------

// File: rtl/div_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_share_arbiter
// Description : Round-robin arbiter that shares one external divider among
//               NUM_REQ requesters, one divide in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module div_share_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int NUMER_DW    = 16,
  parameter  int DENOM_DW    = 16,
  parameter  int TIMEOUT_CYC = 64,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*NUMER_DW-1:0]  i_numer_bus,
  input  logic [NUM_REQ*DENOM_DW-1:0]  i_denom_bus,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_div_en,
  output logic [NUMER_DW-1:0]          o_div_numer,
  output logic [DENOM_DW-1:0]          o_div_denom,
  input  logic [NUMER_DW-1:0]          i_div_quotient,
  input  logic                         i_div_quotient_vld,
  output logic [NUMER_DW-1:0]          o_result,
  output logic [ID_W-1:0]              o_result_id,
  output logic                         o_result_vld,
  output logic                         o_dbz,
  output logic                         o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic [ID_W-1:0]     result_id_q, result_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUMER_DW-1:0] numer_q, numer_d;
  logic [DENOM_DW-1:0] denom_q, denom_d;
  logic [NUMER_DW-1:0] div_numer_q, div_numer_d;
  logic [DENOM_DW-1:0] div_denom_q, div_denom_d;
  logic [NUMER_DW-1:0] result_q, result_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                div_en_q, div_en_d;
  logic                result_vld_q, result_vld_d;
  logic                dbz_q, dbz_d;
  logic                timeout_q, timeout_d;

  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // First asserted requester at or after the round-robin pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && i_req[wrap_add(rr_ptr_q, i)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      result_id_q  <= '0;
      cnt_q        <= '0;
      numer_q      <= '0;
      denom_q      <= '0;
      div_numer_q  <= '0;
      div_denom_q  <= '0;
      result_q     <= '0;
      grant_q      <= '0;
      div_en_q     <= 1'b0;
      result_vld_q <= 1'b0;
      dbz_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      result_id_q  <= result_id_d;
      cnt_q        <= cnt_d;
      numer_q      <= numer_d;
      denom_q      <= denom_d;
      div_numer_q  <= div_numer_d;
      div_denom_q  <= div_denom_d;
      result_q     <= result_d;
      grant_q      <= grant_d;
      div_en_q     <= div_en_d;
      result_vld_q <= result_vld_d;
      dbz_q        <= dbz_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    result_id_d  = result_id_q;
    cnt_d        = cnt_q;
    numer_d      = numer_q;
    denom_d      = denom_q;
    div_numer_d  = div_numer_q;
    div_denom_d  = div_denom_q;
    result_d     = result_q;
    dbz_d        = dbz_q;
    timeout_d    = timeout_q;
    grant_d      = '0;
    div_en_d     = 1'b0;
    result_vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          win_d   = sel_idx;
          numer_d = i_numer_bus[int'(sel_idx)*NUMER_DW +: NUMER_DW];
          denom_d = i_denom_bus[int'(sel_idx)*DENOM_DW +: DENOM_DW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        grant_d[win_q] = 1'b1;
        rr_ptr_d       = wrap_add(win_q, 1);
        result_id_d    = win_q;
        div_numer_d    = numer_q;
        div_denom_d    = denom_q;
        cnt_d          = '0;
        if (denom_q != '0) begin
          div_en_d = 1'b1;
          state_d  = S_WAIT;
        end else begin
          result_d = '1;
          dbz_d    = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_WAIT: begin
        if (i_div_quotient_vld) begin
          result_d = i_div_quotient;
          dbz_d    = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Divider never answered: report a zero result and latch the error.
          result_d  = '0;
          dbz_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        result_vld_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_grant      = grant_q;
  assign o_div_en     = div_en_q;
  assign o_div_numer  = div_numer_q;
  assign o_div_denom  = div_denom_q;
  assign o_result     = result_q;
  assign o_result_id  = result_id_q;
  assign o_result_vld = result_vld_q;
  assign o_dbz        = dbz_q;
  assign o_timeout    = timeout_q;

endmodule
`default_nettype wire
